handball: RTL and testbench
===========================

# handball

Single-player "lampball" game core driving an 8-LED bar. A lit LED (the ball) is served from the leftmost position, travels right, bounces off the right end, and must be struck with the player button when it returns to the leftmost position. It sits between the board's debounced push-button/switch inputs and the LED bank, with one system clock.

## Interface
- TICKS, 1, clock cycles per ball step (≥1); 1 = one LED position per clock.
- CLKK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-low reset.
- START  in  1  level: while high, (re)load ball at leftmost and hold it there.
- PULSER  in  1  player button (active-high, debounced externally); only rising edges count.
- LGOUT  out  8  one-hot ball position; bit 7 = leftmost, bit 0 = rightmost; all zero = no ball.

## Operation
- Press = PULSER high this cycle and low the previous cycle (one registered sample `pulser_q`).
- States: IDLE, SERVE, RIGHT, LEFT, WINDOW.
- IDLE: LGOUT=0x00. Presses are ignored.
- Priority each edge, highest first: RESET low, then START high, then the game FSM.
- START high, any state → SERVE, LGOUT=0x80, step counter cleared. Presses are ignored while START is high.
- SERVE (START low): a press → RIGHT, LGOUT=0x40 on that edge.
- RIGHT: each step shifts LGOUT right by 1. When LGOUT=0x01, the next step sets LGOUT=0x02 and the state → LEFT (automatic bounce).
- LEFT: each step shifts LGOUT left by 1. When the shift produces 0x80, the state → WINDOW.
- WINDOW (ball at 0x80, lasts one step period):
  - A press → RIGHT, LGOUT=0x40 on the edge the press is sampled.
  - No press by the end of the period → IDLE, LGOUT=0x00 (ball lost).
- Press in RIGHT or LEFT (wrong time) → IDLE, LGOUT=0x00 on that edge.
- LGOUT is always one-hot or zero. It never holds more than one bit set.

## Timing
- RESET low at an edge → IDLE, LGOUT=0x00, pulser_q=0, counter=0. This applies mid-game too.
- All outputs are registered, so there is no combinational path from inputs to LGOUT.
- Step counter counts 0..TICKS-1. A step occurs when it wraps. It restarts at 0 on every state entry caused by START or by a press.
- With TICKS=1, counting edges from the serve press at edge k:
  - 0x40 at k
  - 0x01 at k+6
  - 0x02 at k+7
  - 0x80 (WINDOW) at k+13
  - press sampled at k+14 → 0x40
  - no press by k+14 → 0x00
- A PULSER held high generates only one press. It must return low for at least one cycle before the next press.
- START and a press in the same cycle: START wins, giving SERVE with 0x80.

## Structure
- Shared package `handball_pkg`:
  - state enum
  - LED constants LED_LEFT=8'h80, LED_RIGHT=8'h01, LED_OFF=8'h00
- Optional sub-module `step_timer`: parameterised TICKS counter producing a one-cycle step strobe with synchronous clear.
- The FSM and LED register live in the top module.

## Test plan
- Reset: RESET=0 for 2 cycles with START=1 and PULSER=1 → LGOUT=0x00 throughout.
- Serve and rally, TICKS=1: START=1 → 0x80. Then START=0 and a 1-cycle press → LGOUT sequence 0x40, 0x20 … 0x01, 0x02 … 0x80 in consecutive cycles. Then a press in the WINDOW cycle → 0x40 next.
- Miss: no press while in WINDOW → LGOUT=0x00 one step later. The state stays IDLE until START.
- Wrong-time press: press while LGOUT=0x10 moving left → 0x00 on the next edge. A later START=1 → 0x80.
- START dominance: START=1 with PULSER held high for several cycles → LGOUT stays 0x80. Dropping START while PULSER is still high does not serve; a fresh press does.
- TICKS=3: each LED position holds exactly 3 cycles, and WINDOW lasts 3 cycles. A press in the 3rd cycle of the window is accepted.

Source files
------------

// File: rtl/handball_pkg.sv
// Shared types and constants for the handball lampball game core.
// Ball positions are one-hot LED codes, bit 7 being the serve/strike end.
package handball_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SERVE  = 3'd1,
      ST_RIGHT  = 3'd2,
      ST_LEFT   = 3'd3,
      ST_WINDOW = 3'd4
   } state_e;

   localparam logic [7:0] LED_LEFT  = 8'h80;
   localparam logic [7:0] LED_RIGHT = 8'h01;
   localparam logic [7:0] LED_OFF   = 8'h00;
   localparam logic [7:0] LED_NEXT  = 8'h40;
   localparam logic [7:0] LED_BOUNCE = 8'h02;

endpackage

// File: rtl/handball_step_timer.sv
// Ball step timer: counts 0..TICKS-1 while enabled and strobes step on the wrap.
// A synchronous clear restarts the period from zero.
module handball_step_timer #(
   parameter int TICKS = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic step
);

   localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign step = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/handball.sv
// Lampball game core: serves, moves and bounces a one-hot ball across an 8-LED bar.
// Handshake-free: START is a level, PULSER counts only on its rising edge, LGOUT is registered.
module handball
   import handball_pkg::*;
#(
   parameter int TICKS = 1
) (
   input  logic       CLKK,
   input  logic       RESET,
   input  logic       START,
   input  logic       PULSER,
   output logic [7:0] LGOUT,
   output state_e     state_dbg
);

   state_e     state_q, state_d;
   logic [7:0] led_q, led_d;
   logic       pulser_q, pulser_d;
   logic       press;
   logic       step;
   logic       timer_clr;
   logic       timer_en;

   assign press     = PULSER && !pulser_q;
   assign timer_clr = START || press;
   assign timer_en  = (state_q == ST_RIGHT) || (state_q == ST_LEFT) || (state_q == ST_WINDOW);

   handball_step_timer #(.TICKS(TICKS)) u_timer (
      .clk   (CLKK),
      .rst_n (RESET),
      .clr   (timer_clr),
      .en    (timer_en),
      .step  (step)
   );

   always_comb begin
      state_d  = state_q;
      led_d    = led_q;
      pulser_d = PULSER;
      if (START) begin
         state_d = ST_SERVE;
         led_d   = LED_LEFT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               led_d = LED_OFF;
            end
            ST_SERVE: begin
               if (press) begin
                  state_d = ST_RIGHT;
                  led_d   = LED_NEXT;
               end
            end
            ST_RIGHT: begin
               if (press) begin
                  state_d = ST_IDLE;
                  led_d   = LED_OFF;
               end else if (step) begin
                  if (led_q == LED_RIGHT) begin
                     state_d = ST_LEFT;
                     led_d   = LED_BOUNCE;
                  end else begin
                     led_d = led_q >> 1;
                  end
               end
            end
            ST_LEFT: begin
               if (press) begin
                  state_d = ST_IDLE;
                  led_d   = LED_OFF;
               end else if (step) begin
                  led_d = led_q << 1;
                  if (led_q == LED_NEXT) begin
                     state_d = ST_WINDOW;
                  end
               end
            end
            ST_WINDOW: begin
               // A strike sampled on the final edge of the window still counts.
               if (press) begin
                  state_d = ST_RIGHT;
                  led_d   = LED_NEXT;
               end else if (step) begin
                  state_d = ST_IDLE;
                  led_d   = LED_OFF;
               end
            end
            default: begin
               state_d = ST_IDLE;
               led_d   = LED_OFF;
            end
         endcase
      end
   end

   always_ff @(posedge CLKK) begin
      if (!RESET) begin
         state_q  <= ST_IDLE;
         led_q    <= LED_OFF;
         pulser_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         led_q    <= led_d;
         pulser_q <= pulser_d;
      end
   end

   assign LGOUT     = led_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_handball.sv
// Bench for handball: a TICKS=1 and a TICKS=3 instance share stimulus; expected LED
// values are queued as each cycle is driven and compared after the edge.
module tb_handball;
   import handball_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       pulser;
   logic [7:0] lg1;
   logic [7:0] lg3;
   state_e     st1;
   state_e     st3;

   logic [7:0] exp_q[$];
   int         n_checks;
   int         n_fail;
   bit         sel3;

   handball #(.TICKS(1)) dut1 (
      .CLKK      (clk),
      .RESET     (rst_n),
      .START     (start),
      .PULSER    (pulser),
      .LGOUT     (lg1),
      .state_dbg (st1)
   );

   handball #(.TICKS(3)) dut3 (
      .CLKK      (clk),
      .RESET     (rst_n),
      .START     (start),
      .PULSER    (pulser),
      .LGOUT     (lg3),
      .state_dbg (st3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%02h exp=%02h t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs mid-cycle, queue the LED value expected after the edge.
   task automatic cyc(input logic r, input logic s, input logic p,
                      input logic [7:0] exp, input string tag);
      logic [7:0] e;
      @(negedge clk);
      rst_n  = r;
      start  = s;
      pulser = p;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check({tag, "_noexp"}, 8'h00, 8'hff);
      end else begin
         e = exp_q.pop_front();
         check(tag, sel3 ? lg3 : lg1, e);
      end
   endtask

   // Ball flight after the strike edge (which already showed 0x40): right to 0x01,
   // bounce, back to 0x80, each position held for ticks cycles.
   task automatic rally(input int ticks, input string tag);
      logic [7:0] v;
      for (int i = 0; i < 14; i++) begin
         v = 8'h40;
         if (i <= 6) v = v >> i;
         else begin
            v = 8'h01;
            v = v << (i - 6);
         end
         for (int t = 0; t < ticks; t++) begin
            if (!(i == 0 && t == 0)) cyc(1, 0, 0, v, tag);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      sel3     = 1'b0;
      rst_n    = 1'b0;
      start    = 1'b1;
      pulser   = 1'b1;

      // Reset with START and PULSER asserted keeps the bar dark.
      cyc(0, 1, 1, 8'h00, "reset0");
      cyc(0, 1, 1, 8'h00, "reset1");
      check("reset_dut3", lg3, 8'h00);
      check("reset_state", 8'(st1), 8'(ST_IDLE));

      // Serve and full rally at TICKS=1, strike in window, then a miss.
      cyc(1, 1, 0, 8'h80, "serve");
      cyc(1, 0, 0, 8'h80, "serve_hold");
      cyc(1, 0, 1, 8'h40, "serve_press");
      rally(1, "rally1");
      cyc(1, 0, 1, 8'h40, "strike1");
      rally(1, "rally2");
      cyc(1, 0, 0, 8'h00, "miss1");
      check("miss_state", 8'(st1), 8'(ST_IDLE));
      cyc(1, 0, 0, 8'h00, "idle_a");
      cyc(1, 0, 1, 8'h00, "idle_press");
      cyc(1, 0, 0, 8'h00, "idle_b");

      // Wrong-time press while 0x10 is moving left.
      cyc(1, 1, 0, 8'h80, "wt_serve");
      cyc(1, 0, 1, 8'h40, "wt_press");
      for (int i = 1; i <= 6; i++) cyc(1, 0, 0, 8'(8'h40 >> i), "wt_right");
      cyc(1, 0, 0, 8'h02, "wt_bounce");
      cyc(1, 0, 0, 8'h04, "wt_left4");
      cyc(1, 0, 0, 8'h08, "wt_left8");
      cyc(1, 0, 0, 8'h10, "wt_left10");
      cyc(1, 0, 1, 8'h00, "wt_lost");
      cyc(1, 0, 0, 8'h00, "wt_idle");
      cyc(1, 1, 0, 8'h80, "wt_reserve");

      // START dominance with PULSER held, then a fresh press serves.
      for (int i = 0; i < 4; i++) cyc(1, 1, 1, 8'h80, "dom_hold");
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 8'h80, "dom_nopress");
      cyc(1, 0, 0, 8'h80, "dom_release");
      cyc(1, 0, 1, 8'h40, "dom_press");
      cyc(1, 0, 0, 8'h20, "dom_move");
      cyc(1, 0, 1, 8'h00, "dom_wrong");

      // Mid-game reset.
      cyc(1, 1, 0, 8'h80, "mr_serve");
      cyc(1, 0, 1, 8'h40, "mr_press");
      cyc(1, 0, 0, 8'h20, "mr_move");
      cyc(0, 0, 0, 8'h00, "mr_reset");
      cyc(1, 0, 0, 8'h00, "mr_idle");

      // TICKS=3: every position held 3 cycles, strike in last window cycle, then a miss.
      sel3 = 1'b1;
      cyc(1, 1, 0, 8'h80, "t3_serve");
      cyc(1, 0, 0, 8'h80, "t3_hold");
      cyc(1, 0, 1, 8'h40, "t3_press");
      rally(3, "t3_rally1");
      cyc(1, 0, 1, 8'h40, "t3_strike_last");
      rally(3, "t3_rally2");
      cyc(1, 0, 0, 8'h00, "t3_miss");
      check("t3_miss_state", 8'(st3), 8'(ST_IDLE));

      if (exp_q.size() != 0) check("queue_drained", 8'(exp_q.size()), 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
